wave_capture_trig: RTL and testbench
====================================

// Module: wave_capture_trig
// PURPOSE
//  Parametrised successor of the scope-style capture block. Watches the audio sample
//  stream and detects a configurable level/slope trigger, with optional decimation.
//  Writes DEPTH samples into the half of a double-buffered RAM not being displayed,
//  then waits for the display engine to go idle before swapping halves.
//  Sits between the codec/sample path and the wave display RAM.
// PARAMETERS
//  IN_W        16   width of signed (two's complement) input sample
//  OUT_W        8   width of stored sample, offset binary
//  ADDR_W       8   log2(DEPTH); DEPTH = 2**ADDR_W samples per frame
//  AUTO_TMO  1024   accepted samples in ARMED before a forced trigger (AUTO_TRIGGER_EN only)
// PORTS
//  clk               in   1        system clock
//  reset             in   1        synchronous, active-high reset
//  new_sample_ready  in   1        one-cycle strobe: new_sample_in valid
//  new_sample_in     in   IN_W     signed sample
//  wave_display_idle in   1        display finished with current half
//  trig_level        in   IN_W     signed trigger threshold
//  trig_slope        in   1        0 = rising crossing, 1 = falling crossing
//  decim             in   8        keep one of every decim+1 strobes (0 = keep all)
//  write_address     out  ADDR_W+1 {~read_index, sample count}
//  write_enable      out  1        one-cycle RAM write strobe
//  write_sample      out  OUT_W    stored sample
//  read_index        out  1        half currently owned by display
//  auto_trig         out  1        current/last frame was force-triggered
// BEHAVIOUR
//  - Reset: state=ARMED, read_index=0, count=0, decim_cnt=0, prev_valid=0; outputs
//    write_enable=0, write_address=0, write_sample=0, auto_trig=0.
//  - Acceptance: strobe with decim_cnt==0 is accepted, decim_cnt<=decim; otherwise decim_cnt-1.
//    Only accepted samples are seen by the FSM. A held-high strobe counts every cycle.
//  - prev register updated on each accepted sample; prev_valid set.
//  - Trigger (signed compare; needs prev_valid): rising = prev<trig_level && cur>=trig_level;
//    falling = prev>=trig_level && cur<trig_level. trig_level/trig_slope used only in ARMED.
//  - FSM: ARMED -> ACTIVE on trigger; the trigger sample is written at count=0.
//    ACTIVE: each accepted sample written at count, count+1; after count==DEPTH-1
//    is written, count<=0, go WAIT.
//    WAIT: samples ignored; on wave_display_idle: read_index toggles, prev_valid<=0, go ARMED.
//    wave_display_idle ignored in ARMED/ACTIVE.
//  - Latency: sample accepted on edge N -> write_enable high for exactly the cycle after edge N,
//    with address/data valid in that cycle; write_enable low at all other times.
//  - write_sample = cur[IN_W-1 -: OUT_W] with MSB inverted (0x8000 -> 0x00, 0x0000 -> 0x80).
//  - Count wraps only via the ACTIVE->WAIT transition; never wraps into the displayed half.
//  - Strobe in the same cycle as the WAIT exit: the sample is dropped, not used as prev.
//  - Reset mid-frame: partial frame abandoned, no further writes; read_index returns to 0.
// CONFIGURATION
//  AUTO_TRIGGER_EN defined: in ARMED, a counter counts accepted samples without a trigger.
//    At AUTO_TMO it forces the trigger on that sample; auto_trig<=1 for the frame.
//    A real trigger sets auto_trig<=0. The counter clears on leaving ARMED.
//  Not defined: no timeout logic; ARMED waits indefinitely; auto_trig tied 0.
// TESTING (ADDR_W=3, IN_W=16, OUT_W=8)
//  1 reset held 2 cycles -> write_enable=0, write_address=0, read_index=0, no writes.
//  2 decim=0, rising, level=0; samples -5,-1,0,3,... -> first write at addr 0x8 with data 0x80,
//    one cycle after the '0' strobe; 8 writes at 0x8..0xF, then none.
//  3 in WAIT, 20 more strobes -> no writes; idle pulse -> read_index=1; next frame at addr 0x0..0x7.
//  4 falling, level=100; samples 200,150,50 -> trigger on 50; data=0x80 (50>>8=0, MSB inverted).
//  5 decim=2; 24 strobes after trigger -> writes on strobes 0,3,6,...; 8 writes total.
//  6 AUTO_TRIGGER_EN, AUTO_TMO=4, constant 0x1234 -> trigger on 4th accepted sample, auto_trig=1;
//    without the macro: no writes ever.

Source files
------------

// File: rtl/wave_capture_trig_if.sv
// Sample-in / RAM-write bus of the triggered wave capture block.
// master = capture block, slave = sample source plus display RAM.
interface wave_capture_trig_if #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 8,
    parameter int ADDR_W = 8
);
    logic                    new_sample_ready;
    logic signed [IN_W-1:0]  new_sample_in;
    logic [ADDR_W:0]         write_address;
    logic                    write_enable;
    logic [OUT_W-1:0]        write_sample;

    modport master (
        input  new_sample_ready, new_sample_in,
        output write_address, write_enable, write_sample
    );

    modport slave (
        output new_sample_ready, new_sample_in,
        input  write_address, write_enable, write_sample
    );
endinterface

// File: rtl/wave_capture_trig.sv
// Level/slope triggered capture of decimated audio into a double-buffered display RAM.
// Define AUTO_TRIGGER_EN to force a trigger after AUTO_TMO accepted samples in ARMED.
module wave_capture_trig #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 8,
    parameter int ADDR_W   = 8,
    parameter int AUTO_TMO = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    wave_capture_trig_if.master    bus,
    input  logic                   wave_display_idle,
    input  logic signed [IN_W-1:0] trig_level,
    input  logic                   trig_slope,
    input  logic [7:0]             decim,
    output logic                   read_index,
    output logic                   auto_trig
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_ARMED,
        S_ACTIVE,
        S_WAIT
    } state_t;

    state_t                 state;
    logic [7:0]             decim_cnt;
    logic [ADDR_W-1:0]      count;
    logic signed [IN_W-1:0] prev;
    logic                   prev_valid;

    logic signed [IN_W-1:0] cur;
    logic                   accepted;
    logic                   hit;
    logic                   force_trig;
    logic [OUT_W-1:0]       sample_enc;

    always_comb begin
        cur        = bus.new_sample_in;
        accepted   = bus.new_sample_ready && (decim_cnt == 8'd0);
        hit        = prev_valid && (trig_slope ? (prev >= trig_level && cur < trig_level)
                                               : (prev < trig_level && cur >= trig_level));
        // Top OUT_W bits with the sign flipped turn two's complement into offset binary.
        sample_enc = {~cur[IN_W-1], cur[IN_W-2 -: OUT_W-1]};
    end

`ifdef AUTO_TRIGGER_EN
    localparam int TMO_W = $clog2(AUTO_TMO + 1);

    logic [TMO_W-1:0] tmo_cnt;

    assign force_trig = !hit && (tmo_cnt == TMO_W'(AUTO_TMO - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt   <= '0;
            auto_trig <= 1'b0;
        end else if (state != S_ARMED) begin
            tmo_cnt <= '0;
        end else if (accepted) begin
            if (hit || force_trig) begin
                tmo_cnt   <= '0;
                auto_trig <= force_trig;
            end else begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
        end
    end
`else
    assign force_trig = 1'b0;
    // Constant low; AUTO_TMO only has an effect when the timeout is built in.
    assign auto_trig  = (AUTO_TMO < 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= S_ARMED;
            read_index        <= 1'b0;
            count             <= '0;
            decim_cnt         <= 8'd0;
            prev              <= '0;
            prev_valid        <= 1'b0;
            bus.write_enable  <= 1'b0;
            bus.write_address <= '0;
            bus.write_sample  <= '0;
        end else begin
            // NOTE: default first, so write_enable is a one-cycle strobe and every
            // register here updates with <= from values sampled before the edge.
            bus.write_enable <= 1'b0;

            if (bus.new_sample_ready)
                decim_cnt <= (decim_cnt == 8'd0) ? decim : decim_cnt - 8'd1;

            case (state)
                S_ARMED: begin
                    if (accepted) begin
                        prev       <= cur;
                        prev_valid <= 1'b1;
                        if (hit || force_trig) begin
                            bus.write_enable  <= 1'b1;
                            bus.write_address <= {~read_index, ADDR_W'(0)};
                            bus.write_sample  <= sample_enc;
                            count             <= ADDR_W'(1);
                            state             <= S_ACTIVE;
                        end
                    end
                end

                S_ACTIVE: begin
                    if (accepted) begin
                        prev              <= cur;
                        bus.write_enable  <= 1'b1;
                        bus.write_address <= {~read_index, count};
                        bus.write_sample  <= sample_enc;
                        if (count == ADDR_W'(DEPTH - 1)) begin
                            count <= '0;
                            state <= S_WAIT;
                        end else begin
                            count <= count + ADDR_W'(1);
                        end
                    end
                end

                S_WAIT: begin
                    // Any strobe in the swap cycle is dropped and never becomes prev.
                    if (wave_display_idle) begin
                        read_index <= ~read_index;
                        prev_valid <= 1'b0;
                        state      <= S_ARMED;
                    end
                end

                default: state <= S_ARMED;
            endcase
        end
    end
endmodule

// File: tb/tb_wave_capture_trig.sv
// Directed bench for wave_capture_trig (ADDR_W=3): per-cycle compare against a
// frame-level behavioural model, plus literal expectations for the key scenarios.
module tb_wave_capture_trig;
    localparam int IN_W     = 16;
    localparam int OUT_W    = 8;
    localparam int ADDR_W   = 3;
    localparam int DEPTH    = 8;
    localparam int AUTO_TMO = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   wave_display_idle;
    logic signed [IN_W-1:0] trig_level;
    logic                   trig_slope;
    logic [7:0]             decim;
    logic                   read_index;
    logic                   auto_trig;

    always #5 clk = ~clk;

    wave_capture_trig_if #(.IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) bus ();

    wave_capture_trig #(
        .IN_W(IN_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .AUTO_TMO(AUTO_TMO)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .bus               (bus),
        .wave_display_idle (wave_display_idle),
        .trig_level        (trig_level),
        .trig_slope        (trig_slope),
        .decim             (decim),
        .read_index        (read_index),
        .auto_trig         (auto_trig)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: phase 0 = armed, 1 = capturing, 2 = waiting for display.
    int         m_decim_left;
    bit         m_have_prev;
    int         m_prev;
    int         m_phase;
    int         m_filled;
    bit         m_half;
    int         m_since;
    bit         m_auto;
    bit         e_we;
    logic [3:0] e_addr;
    logic [7:0] e_data;

    // Writes observed on the DUT bus, for the literal scenario checks.
    int         wr_seen;
    logic [3:0] first_addr;
    logic [7:0] first_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Offset-binary byte: floor(s / 256) shifted up by 128.
    function automatic logic [7:0] enc(input int s);
        return 8'(((s >>> 8) + 128) & 255);
    endfunction

    task automatic model_step(input bit rst, input bit strobe, input int s, input bit idl);
        bit acc;
        bit hit;
        bit forced;
        int lvl;
        lvl  = trig_level;
        e_we = 1'b0;
        if (rst) begin
            m_decim_left = 0; m_have_prev = 0; m_prev = 0; m_phase = 0;
            m_filled = 0; m_half = 0; m_since = 0; m_auto = 0;
            e_addr = 4'h0; e_data = 8'h00;
            return;
        end
        acc = strobe && (m_decim_left == 0);
        if (strobe) m_decim_left = acc ? int'(decim) : m_decim_left - 1;
        if (m_phase == 2) begin
            if (idl) begin
                m_half      = !m_half;
                m_have_prev = 0;
                m_phase     = 0;
            end
        end else if (acc) begin
            if (m_phase == 0) begin
                hit = m_have_prev && (trig_slope ? (m_prev >= lvl && s < lvl)
                                                 : (m_prev < lvl && s >= lvl));
                forced = 0;
`ifdef AUTO_TRIGGER_EN
                if (!hit) begin
                    m_since++;
                    forced = (m_since == AUTO_TMO);
                end
`endif
                if (hit || forced) begin
                    m_auto   = forced;
                    m_since  = 0;
                    m_phase  = 1;
                    m_filled = 0;
                end
            end
            if (m_phase == 1) begin
                e_we   = 1'b1;
                e_addr = 4'((m_half ? 0 : DEPTH) + m_filled);
                e_data = enc(s);
                m_filled++;
                if (m_filled == DEPTH) m_phase = 2;
            end
            m_have_prev = 1;
            m_prev      = s;
        end
    endtask

    // Drive one cycle, advance the model, then compare just after the edge.
    task automatic tick(input bit rst, input bit strobe, input int s, input bit idl);
        reset                = rst;
        bus.new_sample_ready = strobe;
        bus.new_sample_in    = 16'(s);
        wave_display_idle    = idl;
        model_step(rst, strobe, s, idl);
        @(posedge clk);
        #1;
        check("write_enable", 32'(bus.write_enable), 32'(e_we));
        if (e_we) begin
            check("write_address", 32'(bus.write_address), 32'(e_addr));
            check("write_sample", 32'(bus.write_sample), 32'(e_data));
        end
        check("read_index", 32'(read_index), 32'(m_half));
        check("auto_trig", 32'(auto_trig), 32'(m_auto));
        if (bus.write_enable === 1'b1) begin
            if (wr_seen == 0) begin
                first_addr = bus.write_address;
                first_data = bus.write_sample;
            end
            wr_seen++;
        end
    endtask

    task automatic strobe(input int s);
        tick(1'b0, 1'b1, s, 1'b0);
    endtask

    task automatic gap();
        tick(1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic idle_pulse();
        tick(1'b0, 1'b0, 0, 1'b1);
    endtask

    initial begin
        int t2[12] = '{-5, -1, 0, 3, 4, 5, 6, 7, 8, 9, 10, 11};
        int t4[11] = '{50, 200, 150, 50, -300, 32767, -32768, 256, -1, 99, 100};

        decim      = 8'd0;
        trig_slope = 1'b0;
        trig_level = 16'sd0;
        wr_seen    = 0;

        // Reset held two cycles.
        tick(1'b1, 1'b0, 0, 1'b0);
        tick(1'b1, 1'b1, 123, 1'b1);
        check("reset_write_enable", 32'(bus.write_enable), 32'h0);
        check("reset_write_address", 32'(bus.write_address), 32'h0);
        check("reset_read_index", 32'(read_index), 32'h0);
        check("reset_no_writes", 32'(wr_seen), 32'h0);

        // Rising trigger at level 0 fires on the '0' sample, one cycle later.
        wr_seen = 0;
        for (int i = 0; i < 12; i++) begin
            strobe(t2[i]);
            if (i == 1) check("t2_no_write_before_trigger", 32'(wr_seen), 32'd0);
            if (i == 2) check("t2_write_after_trigger", 32'(wr_seen), 32'd1);
        end
        check("t2_frame_writes", 32'(wr_seen), 32'd8);
        check("t2_first_addr", 32'(first_addr), 32'h8);
        check("t2_first_data", 32'(first_data), 32'h80);

        // WAIT ignores samples until the display goes idle, then halves swap.
        wr_seen = 0;
        for (int i = 0; i < 20; i++) strobe(i * 37 - 300);
        check("t3_wait_no_writes", 32'(wr_seen), 32'd0);
        idle_pulse();
        check("t3_read_index_swapped", 32'(read_index), 32'h1);
        idle_pulse();
        check("t3_idle_ignored_in_armed", 32'(read_index), 32'h1);
        wr_seen = 0;
        strobe(-5);
        strobe(0);
        for (int i = 1; i < 8; i++) strobe(i * 1000);
        check("t3_frame_writes", 32'(wr_seen), 32'd8);
        check("t3_first_addr", 32'(first_addr), 32'h0);
        idle_pulse();

        // Falling trigger at 100: a rising crossing must not fire.
        trig_slope = 1'b1;
        trig_level = 16'sd100;
        wr_seen    = 0;
        for (int i = 0; i < 11; i++) begin
            strobe(t4[i]);
            if (i == 2) check("t4_no_trigger_yet", 32'(wr_seen), 32'd0);
        end
        check("t4_frame_writes", 32'(wr_seen), 32'd8);
        check("t4_first_addr", 32'(first_addr), 32'h8);
        check("t4_first_data", 32'(first_data), 32'h80);
        idle_pulse();

        // Decimation by 3 with gaps between some strobes.
        trig_slope = 1'b0;
        trig_level = 16'sd0;
        decim      = 8'd2;
        strobe(-10);
        strobe(-20);
        strobe(-30);
        wr_seen = 0;
        for (int i = 0; i < 24; i++) begin
            strobe(i == 0 ? 5 : i * 513 - 6000);
            if (i % 4 == 1) gap();
        end
        check("t5_decimated_writes", 32'(wr_seen), 32'd8);
        check("t5_first_addr", 32'(first_addr), 32'h0);
        check("t5_first_data", 32'(first_data), 32'h80);
        idle_pulse();
        decim = 8'd0;

        // Constant input: only a timeout can start a frame.
        wr_seen = 0;
        for (int i = 0; i < 12; i++) strobe(16'h1234);
`ifdef AUTO_TRIGGER_EN
        check("t6_auto_writes", 32'(wr_seen), 32'd8);
        check("t6_auto_trig", 32'(auto_trig), 32'h1);
        check("t6_first_addr", 32'(first_addr), 32'h8);
        check("t6_first_data", 32'(first_data), 32'h92);
        idle_pulse();
`else
        check("t6_no_writes", 32'(wr_seen), 32'd0);
        check("t6_auto_trig_low", 32'(auto_trig), 32'h0);
`endif

        // Real trigger, then reset mid-frame abandons the partial frame.
        strobe(-1);
        strobe(1);
        check("t7_real_trigger_auto_low", 32'(auto_trig), 32'h0);
        strobe(2);
        strobe(3);
        tick(1'b1, 1'b1, 4, 1'b0);
        check("t7_reset_read_index", 32'(read_index), 32'h0);
        wr_seen = 0;
        strobe(3);
        strobe(4);
        strobe(5);
        gap();
        check("t7_no_writes_after_reset", 32'(wr_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
